// File: rtl/dpu_pkg.sv
// Shared types and parameter helpers for the streaming dot-product unit.
package dpu_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } dpu_state_e;

  // Accumulator width large enough that LEN full-scale products cannot wrap.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned len);
    return 2 * width + $clog2(len);
  endfunction

endpackage

// File: rtl/Booth_Mult.sv
// Combinational signed radix-4 Booth multiplier; WIDTH=8 gives four partial products.
module Booth_Mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);
  localparam int unsigned P_W = 2 * WIDTH;
  localparam int unsigned NPP = WIDTH / 2;

  logic signed [P_W-1:0] a_ext;
  logic [WIDTH:0]        b_pad;
  logic [2:0]            trip;
  logic signed [P_W-1:0] pp;
  logic [P_W-1:0]        sum;

  assign a_ext = P_W'($signed(a_i));
  assign b_pad = {b_i, 1'b0};

  always_comb begin
    sum  = '0;
    trip = '0;
    pp   = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      trip = b_pad[2*i +: 3];
      pp   = '0;
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      sum = sum + (pp << (2 * i));
    end
  end

  assign p_o = sum;

endmodule

// File: rtl/dot_product_unit.sv
// Streaming signed dot product: operand register -> Booth multiply -> product register -> accumulator.
module dot_product_unit
  import dpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = acc_width(WIDTH, LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum
);
  localparam int unsigned      CNT_W    = $clog2(LEN + 1);
  localparam int unsigned      P_W      = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  dpu_state_e              state_q, state_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic                    v1_q, v1_d, last1_q, last1_d;
  logic [P_W-1:0]          p_q, p_d, prod;
  logic                    v2_q, v2_d, last2_q, last2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    accept, last_in;

  Booth_Mult #(.WIDTH(WIDTH)) u_mult (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  // in_ready is a pure state decode, gated only by reset.
  assign in_ready  = rst_n && (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign accept    = in_valid && in_ready;
  assign last_in   = accept && (in_cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    v1_d     = accept;
    last1_d  = last_in;
    p_d      = p_q;
    v2_d     = v1_q;
    last2_d  = last1_q;
    acc_d    = acc_q;

    if (accept) begin
      a_d      = in_a;
      b_d      = in_b;
      in_cnt_d = last_in ? '0 : in_cnt_q + 1'b1;
    end
    if (v1_q) p_d = prod;
    if (v2_q) acc_d = acc_q + ACC_W'($signed(p_q));

    case (state_q)
      ST_ACCUM: if (last_in) state_d = ST_DRAIN;
      ST_DRAIN: if (v2_q && last2_q) state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // Flush wins over any transfer this cycle, including in-flight products.
    if (clear) begin
      state_d  = ST_ACCUM;
      in_cnt_d = '0;
      v1_d     = 1'b0;
      last1_d  = 1'b0;
      v2_d     = 1'b0;
      last2_d  = 1'b0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      in_cnt_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      p_q      <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      p_q      <= p_d;
      v2_q     <= v2_d;
      last2_q  <= last2_d;
      acc_q    <= acc_d;
    end
  end

endmodule
